// File: rtl/pwm_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_seq_pkg
//  Description : Shared definitions for the PWM duty sequencer: FSM state
//                encoding, default datapath widths and an index-width helper.
//                Optional feature macro used by the sequencer: PWM_SEQ_RAMP_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_seq_pkg;

    localparam int DEF_DUTY_W = 20;
    localparam int DEF_GAP_W  = 12;
    localparam int DEF_HOLD_W = 32;
    localparam int DEF_STEPS  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RAMP = 2'd2,
        ST_HOLD = 2'd3
    } seq_state_t;

    // Width of a table index; a single-entry table still needs one bit.
    function automatic int idx_width(input int steps);
        return (steps > 1) ? $clog2(steps) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_duty_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_sequencer_if
//  Description : Configuration / control / output bundle of the PWM duty
//                sequencer.
//                master : config logic side (drives table writes, start/stop)
//                slave  : sequencer side (drives duty_need/duty_gap/status)
//  Ports       : cfg_we, cfg_idx, cfg_duty, cfg_hold, cfg_gap, cfg_last,
//                cfg_loop, start, stop  (master -> slave)
//                duty_need, duty_gap, busy, step_idx, step_done (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_duty_sequencer_if
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W = DEF_DUTY_W,
    parameter int GAP_W  = DEF_GAP_W,
    parameter int HOLD_W = DEF_HOLD_W,
    parameter int IDX_W  = idx_width(DEF_STEPS)
);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [DUTY_W-1:0] cfg_duty;
    logic [HOLD_W-1:0] cfg_hold;
    logic [GAP_W-1:0]  cfg_gap;
    logic [IDX_W-1:0]  cfg_last;
    logic              cfg_loop;
    logic              start;
    logic              stop;

    logic [DUTY_W-1:0] duty_need;
    logic [GAP_W-1:0]  duty_gap;
    logic              busy;
    logic [IDX_W-1:0]  step_idx;
    logic              step_done;

    modport master (
        output cfg_we, cfg_idx, cfg_duty, cfg_hold, cfg_gap, cfg_last, cfg_loop,
               start, stop,
        input  duty_need, duty_gap, busy, step_idx, step_done
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_duty, cfg_hold, cfg_gap, cfg_last, cfg_loop,
               start, stop,
        output duty_need, duty_gap, busy, step_idx, step_done
    );

endinterface
`default_nettype wire

// File: rtl/pwm_seq_ramp.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_seq_ramp
//  Description : Slew helper for the duty sequencer (used only when
//                PWM_SEQ_RAMP_EN is defined). A prescaler produces one tick
//                every RAMP_DIV cycles while enabled; next_o is the current
//                duty moved RAMP_INC toward the target, clamped to the target.
//  Ports       : clk, rst     - clock, synchronous active-high reset
//                en_i         - prescaler runs while high, cleared while low
//                duty_i/tgt_i - current duty / target duty
//                tick_o       - apply next_o this cycle
//                next_o       - clamped next duty value
//                done_o       - next_o lands exactly on the target
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_seq_ramp #(
    parameter int DUTY_W   = 20,
    parameter int RAMP_DIV = 1000,
    parameter int RAMP_INC = 100
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              en_i,
    input  wire logic [DUTY_W-1:0] duty_i,
    input  wire logic [DUTY_W-1:0] tgt_i,
    output logic                   tick_o,
    output logic      [DUTY_W-1:0] next_o,
    output logic                   done_o
);

    localparam int                PRE_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(RAMP_DIV - 1);
    localparam logic [DUTY_W-1:0] INC      = DUTY_W'(RAMP_INC);

    logic [PRE_W-1:0]  pre_q;
    logic [PRE_W-1:0]  pre_d;
    logic [DUTY_W-1:0] w_diff;

    always_comb begin
        tick_o = (pre_q == PRE_LAST);
        pre_d  = pre_q + 1'b1;
        if (!en_i || tick_o) begin
            pre_d = '0;
        end
    end

    // Compare distance against the increment before adding/subtracting so the
    // result can never overshoot the target or wrap around zero / full scale.
    always_comb begin
        w_diff = '0;
        next_o = tgt_i;
        if (duty_i < tgt_i) begin
            w_diff = tgt_i - duty_i;
            next_o = (w_diff <= INC) ? tgt_i : (duty_i + INC);
        end else begin
            w_diff = duty_i - tgt_i;
            next_o = (w_diff <= INC) ? tgt_i : (duty_i - INC);
        end
        done_o = (next_o == tgt_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_duty_sequencer
//  Description : Plays a table of (duty, hold) steps onto the duty_need /
//                duty_gap inputs of the PWM generator, then stops or loops.
//                Optional macro PWM_SEQ_RAMP_EN: slew duty_need toward each
//                step's target in RAMP_INC increments every RAMP_DIV cycles
//                before the hold count starts.
//  Ports       : clk  - system clock
//                rst  - synchronous reset, active-high (clears table too)
//                bus  - pwm_duty_sequencer_if.slave:
//                       cfg_we/cfg_idx/cfg_duty/cfg_hold : table write
//                       cfg_gap   : gap value, registered every cycle
//                       cfg_last/cfg_loop : latched at start
//                       start/stop: control pulses (stop has priority)
//                       duty_need/duty_gap/busy/step_idx/step_done : outputs
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_duty_sequencer
    import pwm_seq_pkg::*;
#(
    parameter int DUTY_W   = DEF_DUTY_W,
    parameter int GAP_W    = DEF_GAP_W,
    parameter int HOLD_W   = DEF_HOLD_W,
    parameter int STEPS    = DEF_STEPS,
    parameter int RAMP_DIV = 1000,
    parameter int RAMP_INC = 100
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pwm_duty_sequencer_if.slave  bus
);

    localparam int IDX_W = idx_width(STEPS);

    if ((STEPS < 2) || ((STEPS & (STEPS - 1)) != 0) || (RAMP_DIV < 1) || (RAMP_INC < 1))
    begin : g_bad_param
        $error("pwm_duty_sequencer: illegal parameter combination");
    end

    // Step table kept in flops so the synchronous reset can clear it.
    logic [DUTY_W-1:0] tbl_duty_q [STEPS];
    logic [HOLD_W-1:0] tbl_hold_q [STEPS];
    logic [GAP_W-1:0]  gap_q;

    seq_state_t        state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [IDX_W-1:0]  last_q;
    logic              loop_q;
    logic [HOLD_W-1:0] hold_q;
    logic [DUTY_W-1:0] duty_q;
    logic              busy_q;
    logic              done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STEPS; i++) begin
                tbl_duty_q[i] <= '0;
                tbl_hold_q[i] <= '0;
            end
            gap_q <= '0;
        end else begin
            gap_q <= bus.cfg_gap;
            if (bus.cfg_we) begin
                tbl_duty_q[bus.cfg_idx] <= bus.cfg_duty;
                tbl_hold_q[bus.cfg_idx] <= bus.cfg_hold;
            end
        end
    end

`ifdef PWM_SEQ_RAMP_EN
    logic [DUTY_W-1:0] tgt_q;
    logic              w_ramp_tick;
    logic [DUTY_W-1:0] w_ramp_next;
    logic              w_ramp_done;

    pwm_seq_ramp #(
        .DUTY_W   (DUTY_W),
        .RAMP_DIV (RAMP_DIV),
        .RAMP_INC (RAMP_INC)
    ) u_ramp (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q == ST_RAMP),
        .duty_i (duty_q),
        .tgt_i  (tgt_q),
        .tick_o (w_ramp_tick),
        .next_o (w_ramp_next),
        .done_o (w_ramp_done)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            loop_q  <= 1'b0;
            hold_q  <= '0;
            duty_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PWM_SEQ_RAMP_EN
            tgt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            if (bus.stop) begin
                // Abort wins over everything, including a coincident start
                // or a hold expiring in this very cycle.
                state_q <= ST_IDLE;
                idx_q   <= '0;
                duty_q  <= '0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (bus.start) begin
                            state_q <= ST_LOAD;
                            idx_q   <= '0;
                            last_q  <= bus.cfg_last;
                            loop_q  <= bus.cfg_loop;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_LOAD: begin
                        // A zero hold still plays the step for one cycle.
                        hold_q <= (tbl_hold_q[idx_q] == '0) ? HOLD_W'(1) : tbl_hold_q[idx_q];
`ifdef PWM_SEQ_RAMP_EN
                        tgt_q  <= tbl_duty_q[idx_q];
                        state_q <= (tbl_duty_q[idx_q] != duty_q) ? ST_RAMP : ST_HOLD;
`else
                        duty_q  <= tbl_duty_q[idx_q];
                        state_q <= ST_HOLD;
`endif
                    end
`ifdef PWM_SEQ_RAMP_EN
                    ST_RAMP: begin
                        if (w_ramp_tick) begin
                            duty_q <= w_ramp_next;
                            if (w_ramp_done) begin
                                state_q <= ST_HOLD;
                            end
                        end
                    end
`endif
                    ST_HOLD: begin
                        if (hold_q <= HOLD_W'(1)) begin
                            hold_q <= '0;
                            done_q <= 1'b1;
                            if (idx_q < last_q) begin
                                idx_q   <= idx_q + 1'b1;
                                state_q <= ST_LOAD;
                            end else if (loop_q) begin
                                idx_q   <= '0;
                                state_q <= ST_LOAD;
                            end else begin
                                state_q <= ST_IDLE;
                                busy_q  <= 1'b0;
                            end
                        end else begin
                            hold_q <= hold_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.duty_need = duty_q;
    assign bus.duty_gap  = gap_q;
    assign bus.busy      = busy_q;
    assign bus.step_idx  = idx_q;
    assign bus.step_done = done_q;

endmodule
`default_nettype wire

// File: tb/tb_pwm_duty_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_duty_sequencer
//  Description : Self-checking bench for pwm_duty_sequencer. Expected duty
//                transitions and step_done events (finished duty, cycle gap,
//                next index) are queued as stimulus is applied and checked by
//                a negedge monitor. Ramp scenarios apply when PWM_SEQ_RAMP_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_duty_sequencer;

    localparam int DUTY_W   = 20;
    localparam int GAP_W    = 12;
    localparam int HOLD_W   = 32;
    localparam int STEPS    = 4;
    localparam int IDX_W    = 2;
    localparam int RAMP_DIV = 2;
    localparam int RAMP_INC = 30000;

    typedef struct {
        logic [DUTY_W-1:0] duty;
        int                gap;
        int                idx;   // negative: index not checked
    } done_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_duty_sequencer_if #(
        .DUTY_W (DUTY_W), .GAP_W (GAP_W), .HOLD_W (HOLD_W), .IDX_W (IDX_W)
    ) bus ();

    pwm_duty_sequencer #(
        .DUTY_W (DUTY_W), .GAP_W (GAP_W), .HOLD_W (HOLD_W), .STEPS (STEPS),
        .RAMP_DIV (RAMP_DIV), .RAMP_INC (RAMP_INC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int                checks = 0;
    int                errors = 0;
    logic [DUTY_W-1:0] duty_exp [$];
    done_t             done_exp [$];
    bit                mon_en = 1'b0;
    logic [DUTY_W-1:0] prev_duty = '0;
    int                since = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int duty, input int hold);
        bus.cfg_we   = 1'b1;
        bus.cfg_idx  = IDX_W'(idx);
        bus.cfg_duty = DUTY_W'(duty);
        bus.cfg_hold = HOLD_W'(hold);
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic push_done(input int duty, input int gap, input int idx);
        done_t d;
        d.duty = DUTY_W'(duty);
        d.gap  = gap;
        d.idx  = idx;
        done_exp.push_back(d);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        since     = 0;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic pulse_stop();
        duty_exp.push_back('0);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (bus.busy === 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", {63'd0, bus.busy}, 64'd0);
        tick();
    endtask

    task automatic wait_done_empty(input int budget);
        int n = 0;
        while (done_exp.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("done_timeout", 64'(done_exp.size()), 64'd0);
    endtask

    task automatic wait_duty(input int val, input int budget);
        int n = 0;
        while (bus.duty_need !== DUTY_W'(val) && n < budget) begin
            tick();
            n++;
        end
        chk("duty_wait", 64'(bus.duty_need), 64'(val));
    endtask

    task automatic drain(input string tag);
        chk({tag, "_duty_q"}, 64'(duty_exp.size()), 64'd0);
        chk({tag, "_done_q"}, 64'(done_exp.size()), 64'd0);
        duty_exp.delete();
        done_exp.delete();
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.duty_need !== prev_duty) begin
                if (duty_exp.size() == 0) begin
                    chk("duty_unexpected", 64'(bus.duty_need), 64'(prev_duty));
                end else begin
                    chk("duty_seq", 64'(bus.duty_need), 64'(duty_exp.pop_front()));
                end
                prev_duty = bus.duty_need;
            end
            if (bus.step_done === 1'b1) begin
                if (done_exp.size() == 0) begin
                    chk("step_done_unexpected", 64'd1, 64'd0);
                end else begin
                    done_t d;
                    d = done_exp.pop_front();
                    chk("done_duty", 64'(bus.duty_need), 64'(d.duty));
                    chk("done_gap", 64'(since), 64'(d.gap));
                    if (d.idx >= 0) begin
                        chk("done_idx", 64'(bus.step_idx), 64'(d.idx));
                    end
                end
                since = 0;
            end else begin
                since++;
            end
        end
    end

`ifdef PWM_SEQ_RAMP_EN
    localparam int RST_WAIT_DUTY = 80000;
`else
    localparam int RST_WAIT_DUTY = 100000;
`endif

    initial begin
        bus.cfg_we = 1'b0; bus.cfg_idx = '0; bus.cfg_duty = '0; bus.cfg_hold = '0;
        bus.cfg_gap = '0; bus.cfg_last = '0; bus.cfg_loop = 1'b0;
        bus.start = 1'b0; bus.stop = 1'b0;

        // Reset state
        rst = 1'b1;
        tick(); tick();
        chk("rst_duty", 64'(bus.duty_need), 64'd0);
        chk("rst_gap", 64'(bus.duty_gap), 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_idx", 64'(bus.step_idx), 64'd0);
        chk("rst_done", {63'd0, bus.step_done}, 64'd0);
        bus.cfg_gap = 12'h5A5;
        rst = 1'b0;
        tick();
        chk("gap_reg", 64'(bus.duty_gap), 64'h5A5);
        prev_duty = bus.duty_need;
        mon_en = 1'b1;

`ifdef PWM_SEQ_RAMP_EN
        // Ramp up 0 -> 100000, hold, ramp down to 50000 without undershoot
        cfg_write(0, 100000, 3);
        cfg_write(1, 50000, 2);
        bus.cfg_last = 2'd1; bus.cfg_loop = 1'b0;
        duty_exp.push_back(20'd30000); duty_exp.push_back(20'd60000);
        duty_exp.push_back(20'd90000); duty_exp.push_back(20'd100000);
        duty_exp.push_back(20'd70000); duty_exp.push_back(20'd50000);
        push_done(100000, 13, 1);
        push_done(50000, 6, -1);
        pulse_start();
        wait_idle(200);
        chk("ramp_final_duty", 64'(bus.duty_need), 64'd50000);
        drain("ramp");
`else
        // One-shot play of three steps
        cfg_write(0, 100000, 5);
        cfg_write(1, 50000, 3);
        cfg_write(2, 150000, 4);
        bus.cfg_last = 2'd2; bus.cfg_loop = 1'b0;
        duty_exp.push_back(20'd100000); duty_exp.push_back(20'd50000);
        duty_exp.push_back(20'd150000);
        push_done(100000, 7, 1);
        push_done(50000, 3, 2);
        push_done(150000, 4, -1);
        pulse_start();
        chk("busy_after_start", {63'd0, bus.busy}, 64'd1);
        wait_idle(100);
        chk("oneshot_duty_kept", 64'(bus.duty_need), 64'd150000);
        drain("oneshot");

        // Looping play; a second start mid-run must be ignored; stop in step 1
        bus.cfg_loop = 1'b1;
        duty_exp.push_back(20'd100000); duty_exp.push_back(20'd50000);
        duty_exp.push_back(20'd150000); duty_exp.push_back(20'd100000);
        duty_exp.push_back(20'd50000);
        push_done(100000, 7, 1);
        push_done(50000, 3, 2);
        push_done(150000, 4, 0);
        push_done(100000, 5, 1);
        pulse_start();
        tick(); tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done_empty(100);
        pulse_stop();
        chk("stop_busy", {63'd0, bus.busy}, 64'd0);
        chk("stop_idx", 64'(bus.step_idx), 64'd0);
        chk("stop_duty", 64'(bus.duty_need), 64'd0);
        chk("stop_done", {63'd0, bus.step_done}, 64'd0);
        tick(); tick(); tick();
        // start and stop together: stop wins
        bus.start = 1'b1; bus.stop = 1'b1;
        tick();
        bus.start = 1'b0; bus.stop = 1'b0;
        tick();
        chk("start_stop_busy", {63'd0, bus.busy}, 64'd0);
        drain("loop");

        // Zero hold plays one cycle; rewrite of the live entry affects next visit
        cfg_write(0, 20000, 0);
        cfg_write(1, 30000, 2);
        bus.cfg_last = 2'd1; bus.cfg_loop = 1'b1;
        duty_exp.push_back(20'd20000); duty_exp.push_back(20'd30000);
        duty_exp.push_back(20'd20000); duty_exp.push_back(20'd40000);
        push_done(20000, 3, 1);
        push_done(30000, 2, 0);
        push_done(20000, 1, 1);
        pulse_start();
        wait_duty(30000, 50);
        cfg_write(1, 40000, 2);
        wait_done_empty(50);
        pulse_stop();
        tick(); tick(); tick();
        drain("hold0");
`endif

        // Reset mid-operation clears everything, including the table
        cfg_write(0, 100000, 5);
        bus.cfg_last = 2'd0; bus.cfg_loop = 1'b0;
        duty_exp.push_back(DUTY_W'(RST_WAIT_DUTY));
        pulse_start();
        wait_duty(RST_WAIT_DUTY, 50);
        duty_exp.push_back('0);
        rst = 1'b1;
        tick();
        chk("midrst_duty", 64'(bus.duty_need), 64'd0);
        chk("midrst_gap", 64'(bus.duty_gap), 64'd0);
        chk("midrst_busy", {63'd0, bus.busy}, 64'd0);
        chk("midrst_idx", 64'(bus.step_idx), 64'd0);
        rst = 1'b0;
        tick();
        bus.cfg_last = 2'd1;
        push_done(0, 3, 1);
        push_done(0, 1, -1);
        pulse_start();
        wait_idle(50);
        chk("zero_table_duty", 64'(bus.duty_need), 64'd0);
        drain("rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
